tt800_seeder: RTL and testbench



---
 rtl/tt800_pkg.sv | 17 +
 rtl/tt800_seeder_lcg32_step.sv | 14 +
 rtl/tt800_seeder.sv | 87 ++++++++
 tb/tb_tt800_seeder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tt800_pkg.sv
// Shared definitions for the TT800 seeding path: FSM states and default
// seeding constants.
package tt800_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WARM = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam int          TT800_WORDS = 25;  // 18 + 7 state words
  localparam int          WARMUP_DEF  = 64;
  localparam logic [31:0] LCG_A_DEF   = 32'd69069;
  localparam logic [31:0] LCG_C_DEF   = 32'd1;

endpackage

// File: rtl/tt800_seeder_lcg32_step.sv
// One combinational LCG step, y = A*x + C mod 2^32. Kept separate so the
// multiplier can be pipelined or timing-constrained on its own.
module lcg32_step #(
  parameter logic [31:0] A = 32'd69069,
  parameter logic [31:0] C = 32'd1
) (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);

  // 32-bit context keeps only the low half of the product
  assign o_y = A * i_x + C;

endmodule

// File: rtl/tt800_seeder.sv
// Seeds the TT800 generator: expands one seed into NWORDS LCG words shifted
// in with init=1, runs WARMUP discard cycles, then hands en to the consumer.
module tt800_seeder
  import tt800_pkg::*;
#(
  parameter int          NWORDS = TT800_WORDS,
  parameter int          WARMUP = WARMUP_DEF,
  parameter logic [31:0] LCG_A  = LCG_A_DEF,
  parameter logic [31:0] LCG_C  = LCG_C_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic        gen_en,
  output logic        prng_en,
  output logic        prng_init,
  output logic [31:0] prng_initv,
  output logic        busy,
  output logic        ready
);

  localparam int MAXC = (NWORDS > WARMUP) ? NWORDS : WARMUP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LAST_LD = CW'(NWORDS - 1);
  localparam logic [CW-1:0] LAST_WM = CW'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e          r_state, w_state_nx;
  logic [31:0]     r_word, w_word_nx, w_lcg;
  logic [CW-1:0]   r_count, w_count_nx;

  lcg32_step #(.A(LCG_A), .C(LCG_C)) u_lcg (
    .i_x (r_word),
    .o_y (w_lcg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_word  <= w_word_nx;
      r_count <= w_count_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_count_nx = r_count;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        if (start) begin
          w_state_nx = S_LOAD;
          w_word_nx  = seed;
          w_count_nx = '0;
        end
      end
      S_LOAD: begin
        w_word_nx  = w_lcg;
        w_count_nx = r_count + CW'(1);
        if (r_count == LAST_LD) begin
          w_count_nx = '0;
          w_state_nx = (WARMUP > 0) ? S_WARM : S_RUN;
        end
      end
      S_WARM: begin
        w_count_nx = r_count + CW'(1);
        if (r_count == LAST_WM) begin
          w_count_nx = '0;
          w_state_nx = S_RUN;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // gen_en passes straight through in RUN, even on a cycle where start wins
  assign busy       = (r_state == S_LOAD) || (r_state == S_WARM);
  assign ready      = (r_state == S_RUN);
  assign prng_init  = (r_state == S_LOAD);
  assign prng_en    = busy || (ready && gen_en);
  assign prng_initv = r_word;

endmodule

// File: tb/tb_tt800_seeder.sv
// Bench for tt800_seeder: default build plus a NWORDS=3/WARMUP=0 build on
// shared stimulus, each compared every cycle against a phase-count model.
module tb_tt800_seeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        gen_en = 1'b0;

  logic        a_en, a_init, a_busy, a_ready;
  logic [31:0] a_initv;
  logic        b_en, b_init, b_busy, b_ready;
  logic [31:0] b_initv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tt800_seeder u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .gen_en(gen_en),
    .prng_en(a_en), .prng_init(a_init), .prng_initv(a_initv),
    .busy(a_busy), .ready(a_ready)
  );

  tt800_seeder #(.NWORDS(3), .WARMUP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .gen_en(gen_en),
    .prng_en(b_en), .prng_init(b_init), .prng_initv(b_initv),
    .busy(b_busy), .ready(b_ready)
  );

  // Model: ph = cycles since the accepted start (0 = idle since reset).
  int          mn[2] = '{25, 3};
  int          mw[2] = '{64, 0};
  int          ph[2] = '{0, 0};
  logic [31:0] msd[2];

  function automatic logic [31:0] lcgk(input logic [31:0] s, input int k);
    longint unsigned x = longint'(s);
    for (int i = 0; i < k; i++) x = (x * 64'd69069 + 64'd1) & 64'hFFFF_FFFF;
    return x[31:0];
  endfunction

  function automatic logic [35:0] expv(input int m, input logic ge);
    int p = ph[m];
    int n = mn[m];
    int w = mw[m];
    logic bz = (p >= 1) && (p <= n + w);
    logic rd = (p > n + w);
    logic in = (p >= 1) && (p <= n);
    logic [31:0] iv = (p == 0) ? 32'h0 : lcgk(msd[m], (p - 1 < n) ? p - 1 : n);
    return {bz | (rd & ge), in, iv, bz, rd};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check outputs, then advance the model.
  task automatic step(input logic st, input logic [31:0] sd, input logic ge);
    @(negedge clk);
    start = st; seed = sd; gen_en = ge;
    #1;
    chk("dutA", {a_en, a_init, a_initv, a_busy, a_ready}, expv(0, ge));
    chk("dutB", {b_en, b_init, b_initv, b_busy, b_ready}, expv(1, ge));
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) ph[m] = 0;
      else if (st && (ph[m] == 0 || ph[m] > mn[m] + mw[m])) begin
        ph[m] = 1; msd[m] = sd;
      end else if (ph[m] > 0 && ph[m] <= mn[m] + mw[m]) ph[m]++;
    end
  endtask

  function automatic logic rnd_start();
    return (ph[0] >= 1 && ph[0] <= 89) && ($urandom_range(0, 7) == 0);
  endfunction

  logic [31:0] c_seq[4] = '{32'h0, 32'h1, 32'h0001_0DCE, 32'h1C59_83F7};
  int cyc;

  initial begin
    // reset state
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // seed 0: known word sequence and 90-cycle start-to-ready latency
    step(1'b1, 32'h0, 1'b0);
    cyc = 1;
    while (cyc < 200) begin
      #2;
      if (cyc <= 4) chk("seq0", {4'h0, a_initv}, {4'h0, c_seq[cyc-1]});
      if (a_ready) break;
      step(rnd_start(), $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("lat_seed0", 36'(cyc), 36'd90);

    // RUN: gen_en pass-through
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // start with gen_en in RUN, then a second start at LOAD cycle 10
    step(1'b1, 32'd5, 1'b1);
    #2 chk("seed5_first", {a_busy, a_ready, 2'b00, a_initv}, {2'b10, 2'b00, 32'd5});
    cyc = 1;
    while (cyc < 200) begin
      #2;
      if (a_ready) break;
      step(cyc == 10, 32'hCAFE_F00D, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("lat_seed5", 36'(cyc), 36'd90);
    for (int i = 0; i < 4; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));

    // random seed, then async reset mid-WARM
    step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_A", {a_en, a_init, a_initv, a_busy, a_ready}, 36'h0);
    chk("async_rst_B", {b_en, b_init, b_initv, b_busy, b_ready}, 36'h0);
    ph[0] = 0; ph[1] = 0;
    step(1'b0, 32'h0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));

    // fresh seed-0 sequence after reset
    step(1'b1, 32'h0, 1'b0);
    cyc = 1;
    while (cyc < 200) begin
      #2;
      if (cyc <= 4) chk("seq0_again", {4'h0, a_initv}, {4'h0, c_seq[cyc-1]});
      if (a_ready) break;
      step(1'b0, 32'h0, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("lat_again", 36'(cyc), 36'd90);
    for (int i = 0; i < 6; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
